// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   start, op    request and operation code (000 MULT .. 101 MTLO, 110/111 no-op)
//   srca, srcb   operands (srca is also the MTHI/MTLO data)
//   flush        aborts an in-flight multiply/divide
//   busy, done   unit occupied / one-cycle result-written pulse
//   hi, lo       architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 is_div, neg_q, neg_r;
    logic                 accept, take, sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   acc_step, prod_fix;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign busy   = state != IDLE;
    assign take   = start && !busy && !flush;
    assign accept = take && !op[2];

    // A signed divide by zero keeps the raw dividend and no sign fix-up, so the
    // restoring divider naturally yields quotient = all ones, remainder = srca.
    assign sign_a = !op[0] && srca[WIDTH-1] && !(op[1] && srcb == '0);
    assign sign_b = !op[0] && srcb[WIDTH-1];
    assign mag_a  = sign_a ? -srca : srca;
    assign mag_b  = sign_b ? -srcb : srcb;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opb};
    assign acc_step  = !is_div  ? {mul_sum, acc[WIDTH-1:1]} :
                       div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                           {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc : acc;
    assign res_hi   = !is_div ? prod_fix[2*WIDTH-1:WIDTH] :
                      neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign res_lo   = !is_div ? prod_fix[WIDTH-1:0] :
                      neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        state_next = flush            ? IDLE :
                     state == IDLE    ? (accept ? CALC : IDLE) :
                     state == CALC    ? (count == CW'(1) ? FINISH : CALC) :
                                        IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= state == FINISH && !flush;
            if (accept) begin
                count  <= CW'(WIDTH);
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opb    <= mag_b;
                is_div <= op[1];
                neg_q  <= sign_a ^ sign_b;
                neg_r  <= sign_a;
            end else if (state == CALC) begin
                acc   <= acc_step;
                count <= count - 1'b1;
            end
            if (state == FINISH && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (take && op == 3'b100)
                hi <= srca;
            if (take && op == 3'b101)
                lo <= srca;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32 and WIDTH=8 instances).
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, flush;
    logic [2:0]    op;
    logic [W-1:0]  srca, srcb, hi, lo;
    logic          busy, done;
    logic          start8, flush8, busy8, done8;
    logic [2:0]    op8;
    logic [W8-1:0] a8, b8, hi8, lo8;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(a8), .srcb(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t         q[$], q8[$];
    int           errors = 0, checks = 0, cyc = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint sx(input logic [31:0] v, input int w);
        longint t;
        t = longint'({32'b0, v});
        return (t <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference: plain integer arithmetic on sign-extended / zero-extended operands.
    function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, ua, ub, h, l, p;
        longint      sa, sb;
        m  = (64'd1 << w) - 1;
        sa = sx(a, w);
        sb = sx(b, w);
        ua = {32'b0, a} & m;
        ub = {32'b0, b} & m;
        if (o < 2) begin
            p = (o == 0) ? 64'(sa * sb) : ua * ub;
            return (w == 32) ? p : p & ((64'd1 << (2 * w)) - 1);
        end
        if (ub == 0) begin
            h = ua;
            l = m;
        end else if (o == 2) begin
            h = 64'(sa % sb);
            l = 64'(sa / sb);
        end else begin
            h = ua % ub;
            l = ua / ub;
        end
        return ((h & m) << w) | (l & m);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0)
                chk("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.at));
                m_hi = e.res[2*W-1:W];
                m_lo = e.res[W-1:0];
            end
        end else if (q.size() > 0 && cyc >= q[0].at) begin
            chk("missing_done", 0, 1);
            void'(q.pop_front());
        end
        if (reset) begin
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0)
                chk("spurious_done8", 1, 0);
            else begin
                e = q8.pop_front();
                chk("done_cycle8", 64'(cyc), 64'(e.at));
                chk("hi8", 64'(hi8), 64'(e.res[2*W8-1:W8]));
                chk("lo8", 64'(lo8), 64'(e.res[W8-1:0]));
            end
        end else if (q8.size() > 0 && cyc >= q8[0].at) begin
            chk("missing_done8", 0, 1);
            void'(q8.pop_front());
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int t);
        int g = 0;
        while (busy && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (busy) chk("issue_wait", 1, 0);
        start = 1'b1; op = o; srca = a; srcb = b; t = cyc;
        @(posedge clk);
        if (o < 4) q.push_back('{res: model(W, o, a, b), at: t + W + 2});
        else if (o == 4) m_hi = a;
        else if (o == 5) m_lo = a;
        #1;
        start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, output int t);
        int g = 0;
        while (busy8 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (busy8) chk("issue8_wait", 1, 0);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b; t = cyc;
        @(posedge clk);
        if (o < 4) q8.push_back('{res: model(W8, o, {24'b0, a}, {24'b0, b}), at: t + W8 + 2});
        #1;
        start8 = 1'b0;
    endtask

    task automatic run_check(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int t;
        issue(o, a, b, t);
        wait_to(t + W + 2);
        @(negedge clk);
        chk({name, "_hi"}, 64'(hi), 64'(ehi));
        chk({name, "_lo"}, 64'(lo), 64'(elo));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t, t1, t2;
        logic [2:0] o;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", 64'(hi), 0);
        chk("rst_lo", 64'(lo), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // First cycle out of reset: MULT accepted, busy profile and result.
        issue(3'b000, 32'hFFFF_FFFD, 32'h5, t);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            chk("busy_profile", busy, (cyc >= t + 1 && cyc <= t + W + 1));
        end
        chk("mult_done", done, 1);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
        @(posedge clk);
        #1;

        run_check(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
        run_check(3'b010, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_check(3'b011, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, "divu_zero");
        run_check(3'b010, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
        run_check(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");

        // MTLO then DIV flushed mid-calculation.
        issue(3'b101, 32'h1234_5678, 32'h0, t);
        issue(3'b010, 32'd100, 32'd7, t);
        wait_to(t + 10);
        flush = 1'b1;
        @(posedge clk);
        void'(q.pop_back());
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_lo", 64'(lo), 64'h1234_5678);
        @(posedge clk);
        #1;

        // Flush together with start in IDLE drops the start.
        start = 1'b1; op = 3'b100; srca = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", busy, 0);
        @(posedge clk);
        #1;

        // Flush in FINISH: no write, no done.
        issue(3'b000, 32'h7, 32'h9, t);
        wait_to(t + W + 1);
        flush = 1'b1;
        @(posedge clk);
        void'(q.pop_back());
        #1 flush = 1'b0;

        // Start while busy is ignored; no-op codes change nothing.
        issue(3'b011, 32'd1000, 32'd33, t);
        wait_to(t + 3);
        start = 1'b1; op = 3'b100; srca = 32'hCAFE_F00D;
        @(posedge clk);
        #1 start = 1'b0;
        issue(3'b110, 32'h1111_1111, 32'h2, t);
        issue(3'b111, 32'h2222_2222, 32'h3, t);

        // Reset aborts a MULT, then back-to-back MULTs.
        issue(3'b000, 32'h1234, 32'h5678, t);
        wait_to(t + 5);
        reset = 1'b0;
        @(posedge clk);
        q.delete();
        m_hi = '0;
        m_lo = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", 64'(hi), 0);
        chk("reset_lo", 64'(lo), 0);
        @(posedge clk);
        #1;
        issue(3'b000, 32'hFFFF_0001, 32'h0001_0003, t1);
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, t2);
        chk("back_to_back", 64'(t2), 64'(t1 + W + 2));

        // Randomized traffic with occasional flush and ignored starts.
        repeat (80) begin
            o = 3'($urandom_range(0, 7));
            issue(o, rnd(), rnd(), t);
            if (o < 4) begin
                case ($urandom_range(0, 9))
                    0: begin
                        wait_to(t + $urandom_range(1, W + 1));
                        flush = 1'b1;
                        @(posedge clk);
                        void'(q.pop_back());
                        #1 flush = 1'b0;
                    end
                    1: begin
                        wait_to(t + 2);
                        start = 1'b1; op = 3'($urandom); srca = $urandom;
                        @(posedge clk);
                        #1 start = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        // WIDTH=8 instance.
        issue8(3'b010, 8'h81, 8'h03, t);
        wait_to(t + W8 + 2);
        @(negedge clk);
        chk("div8_done", done8, 1);
        chk("div8_hi", 64'(hi8), 64'hFF);
        chk("div8_lo", 64'(lo8), 64'hD6);
        @(posedge clk);
        #1;
        repeat (40) issue8(3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), t);

        repeat (W + 6) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0 || q8.size() != 0) chk("drain", 64'(q.size() + q8.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO width; any even value 8..64 SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; the block SHALL reset at a clk edge where reset==0.
REQ-004 start  input  1  request; sampled only while busy==0.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-006 srca  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-007 srcb  input  WIDTH  multiplier / divisor.
REQ-008 flush  input  1  pipeline flush; aborts the in-flight operation.
REQ-009 busy  output  1  high while state != IDLE; the pipeline SHALL stall HI/LO readers on it.
REQ-010 done  output  1  one-cycle pulse; hi/lo already hold the new result in that cycle.
REQ-011 hi  output  WIDTH  HI register.
REQ-012 lo  output  WIDTH  LO register.

Function
REQ-013 FSM states SHALL be IDLE, CALC and FINISH; busy = (state != IDLE).
REQ-014 Acceptance: start==1, busy==0 and flush==0 in cycle T with op 000-011 -> CALC from T+1, iteration counter = WIDTH.
REQ-015 Signed ops SHALL latch operand magnitudes and result signs at acceptance; unsigned ops SHALL latch operands unchanged.
REQ-016 CALC SHALL run exactly WIDTH cycles: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle; then FINISH.
REQ-017 FINISH SHALL last 1 cycle, apply the sign fix-up and write hi/lo at its end edge; the next state is IDLE.
REQ-018 Latency: busy==1 in cycles T+1..T+WIDTH+1; done==1 and new hi/lo in cycle T+WIDTH+2 only.
REQ-019 MULT/MULTU: {hi,lo} SHALL be the full 2*WIDTH-bit product, two's-complement for MULT.
REQ-020 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 Divide by zero (srcb==0), signed or unsigned: lo SHALL be all ones and hi SHALL be srca; no exception is raised.
REQ-022 DIV with srca = most-negative and srcb = -1: lo SHALL be the most-negative value, hi = 0.
REQ-023 MTHI/MTLO accepted in cycle T: hi (or lo) = srca from T+1; busy SHALL stay 0 and done SHALL stay 0.
REQ-024 op 110/111 with start SHALL change no state.
REQ-025 start while busy==1 SHALL be ignored; no queueing.
REQ-026 A start in the cycle done==1 (state IDLE) SHALL be accepted normally.
REQ-027 flush==1 in CALC or FINISH -> IDLE at the next edge; hi/lo unchanged and done not asserted.
REQ-028 flush has priority over start in the same cycle; start is dropped.
REQ-029 hi/lo SHALL change only per REQ-017, REQ-023 or reset.

Reset
REQ-030 reset==0 at an edge SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, aborting any in-flight operation.
REQ-031 reset SHALL take priority over flush, start and FSM progress.
REQ-032 The first start SHALL be accepted in the first cycle with reset==1.

Verification (WIDTH=32 unless stated)
REQ-033 MULT srca=FFFFFFFD, srcb=00000005, accepted at T -> cycle T+34: done=1, hi=FFFFFFFF, lo=FFFFFFF1; busy=1 in T+1..T+33.
REQ-034 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; DIV srca=FFFFFFF9, srcb=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-035 DIVU srca=7, srcb=0 -> lo=FFFFFFFF, hi=00000007; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-036 MTLO 12345678 followed by DIV, flush at T+10 -> busy=0 at T+11, lo stays 12345678, no done pulse.
REQ-037 reset=0 at T+5 of MULT -> all outputs 0 next cycle; then back-to-back MULTs with the second start issued in the done cycle of the first -> both results correct.
REQ-038 WIDTH=8: DIV 8'h81/8'h03 -> lo=8'hD6, hi=8'hFF; done at T+10.
